// File: rtl/jk_ff.sv
// Bank of WIDTH independent edge-triggered JK flip-flops with complementary outputs.
// The async active-low reset loads RESET_VAL. Qbar is always the inverse of the one state register.
module jk_ff #(
  parameter int unsigned           WIDTH     = 1,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar
);

  logic [WIDTH-1:0] q_r;

  // Per bit: set where J & ~Q, keep where ~K & Q (covers hold/clear/set/toggle)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_r <= RESET_VAL;
    else        q_r <= (J & ~q_r) | (~K & q_r);
  end

  assign Q    = q_r;
  assign Qbar = ~q_r;

endmodule

// File: tb/tb_jk_ff.sv
// Self-checking bench for jk_ff: directed scenarios on a 1-bit and a 4-bit instance,
// then randomized JK/reset stimulus against a truth-table reference model.
module tb_jk_ff;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] j, k, q, qbar;
  logic [3:0] j4, k4, q4, qbar4;

  int checks = 0;
  int errors = 0;

  logic [0:0] m;
  logic [3:0] m4;

  localparam logic [3:0] RV4 = 4'b1010;

  always #5 clk = ~clk;

  jk_ff dut (
    .clk(clk), .rst_n(rst_n), .J(j), .K(k), .Q(q), .Qbar(qbar)
  );

  jk_ff #(.WIDTH(4), .RESET_VAL(4'b1010)) dut4 (
    .clk(clk), .rst_n(rst_n), .J(j4), .K(k4), .Q(q4), .Qbar(qbar4)
  );

  // Reference: look up each bit's action by name in the JK truth table
  function automatic logic ref_bit(input logic qb, input logic jb, input logic kb);
    case ({jb, kb})
      2'b00:   return qb;    // hold
      2'b01:   return 1'b0;  // clear
      2'b10:   return 1'b1;  // set
      default: return !qb;   // toggle
    endcase
  endfunction

  function automatic logic [3:0] ref_vec(input logic [3:0] qv, input logic [3:0] jv, input logic [3:0] kv);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ref_bit(qv[i], jv[i], kv[i]);
    return r;
  endfunction

  // One rising edge; models follow the sampled inputs, then settle 1ns past the edge
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      m  = ref_bit(m[0], j[0], k[0]);
      m4 = ref_vec(m4, j4, k4);
    end
    #1;
  endtask

  task automatic test_reset();
    j = 1'b1; k = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (q !== 1'b0 || qbar !== 1'b1) begin errors++; $display("FAIL reset_async q=%b qbar=%b need 0/1", q, qbar); end
    checks++; if (q4 !== 4'b1010 || qbar4 !== 4'b0101) begin errors++; $display("FAIL reset_async4 q=%b qbar=%b need 1010/0101", q4, qbar4); end
    tick();
    checks++; if (q !== 1'b0) begin errors++; $display("FAIL reset_edge q=%b need 0", q); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks++; if (q !== 1'b1 || qbar !== 1'b0) begin errors++; $display("FAIL reset_release q=%b qbar=%b need 1/0", q, qbar); end
    // Mid-cycle pulse from Q=1 with J=1,K=0 must clear without a clock edge
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    checks++; if (q !== 1'b0 || qbar !== 1'b1) begin errors++; $display("FAIL reset_pulse q=%b qbar=%b need 0/1", q, qbar); end
    #1 rst_n = 1'b1;
    tick();
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL reset_pulse_release q=%b need 1", q); end
  endtask

  task automatic test_truth_table();
    logic [1:0] pairs [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic       exp   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    j = 1'b0; k = 1'b1;
    tick();
    checks++; if (q !== 1'b0) begin errors++; $display("FAIL tt_clear q=%b need 0", q); end
    for (int i = 0; i < 12; i++) begin
      {j[0], k[0]} = pairs[i % 4];
      tick();
      checks++;
      if (q !== exp[i % 4] || qbar !== ~exp[i % 4]) begin
        errors++; $display("FAIL tt_step%0d q=%b qbar=%b need %b", i, q, qbar, exp[i % 4]);
      end
    end
  endtask

  task automatic test_toggle();
    logic exp;
    j = 1'b1; k = 1'b0;
    tick();
    j = 1'b1; k = 1'b1;
    exp = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp = !exp;
      checks++; if (q !== exp || qbar !== !exp) begin errors++; $display("FAIL toggle%0d q=%b qbar=%b need %b", i, q, qbar, exp); end
    end
  endtask

  task automatic test_hold();
    j = 1'b1; k = 1'b0;
    tick();
    j = 1'b0; k = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (q !== 1'b1) begin errors++; $display("FAIL hold%0d q=%b need 1", i, q); end
    end
    // Glitch J/K between edges, settle back to hold before the next edge
    #2 begin j = 1'b1; k = 1'b1; end
    @(negedge clk); j = 1'b0; k = 1'b1;
    #2 begin j = 1'b0; k = 1'b0; end
    tick();
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL hold_glitch q=%b need 1", q); end
  endtask

  task automatic test_reset_during_toggle();
    j = 1'b1; k = 1'b1;
    tick(); tick();
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    checks++; if (q !== 1'b0 || qbar !== 1'b1) begin errors++; $display("FAIL rst_tog_async q=%b qbar=%b need 0/1", q, qbar); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (q !== 1'b0) begin errors++; $display("FAIL rst_tog_held%0d q=%b need 0", i, q); end
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL rst_tog_release q=%b need 1", q); end
  endtask

  task automatic test_width4();
    j4 = '0; k4 = '0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++; if (q4 !== 4'b1010 || qbar4 !== 4'b0101) begin errors++; $display("FAIL w4_reset q=%b qbar=%b need 1010/0101", q4, qbar4); end
    #1 rst_n = 1'b1;
    j4 = 4'b1100; k4 = 4'b0110;
    tick();
    checks++; if (q4 !== 4'b1100 || qbar4 !== 4'b0011) begin errors++; $display("FAIL w4_step q=%b qbar=%b need 1100/0011", q4, qbar4); end
  endtask

  task automatic test_random();
    @(negedge clk); rst_n = 1'b0;
    #1 begin m = 1'b0; m4 = RV4; end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      j  = 1'($urandom); k  = 1'($urandom);
      j4 = 4'($urandom); k4 = 4'($urandom);
      tick();
      checks++;
      if (q !== m || qbar !== ~m || q4 !== m4 || qbar4 !== ~m4) begin
        errors++; $display("FAIL rand%0d q=%b qbar=%b q4=%b qbar4=%b need q=%b q4=%b", i, q, qbar, q4, qbar4, m, m4);
      end
      if ($urandom_range(7) == 0) begin
        @(negedge clk); rst_n = 1'b0;
        #1 begin m = 1'b0; m4 = RV4; end
        checks++;
        if (q !== m || q4 !== m4 || qbar4 !== ~m4) begin
          errors++; $display("FAIL rand_rst%0d q=%b q4=%b qbar4=%b need 0/1010/0101", i, q, q4, qbar4);
        end
        #1 rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    j = '0; k = '0; j4 = '0; k4 = '0;
    m = '0; m4 = RV4;
    test_reset();
    test_truth_table();
    test_toggle();
    test_hold();
    test_reset_during_toggle();
    test_width4();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
